exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the 5-stage pipelined CPU.
- Inputs: the filtered add/sub overflow flag from EX, external interrupt request lines, and ERET decoded in ID.
- Outputs: pipeline flush, PC redirect to a handler vector or to EPC, and the minimal CP0 state (Status, Cause, EPC).
- Sits beside the hazard unit; the PC mux and the IF/ID/EX pipeline registers consume its outputs.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/exc_ctrl_if.sv | 41 ++++
 rtl/int_pend_arb.sv | 39 +++
 rtl/exc_ctrl.sv | 129 ++++++++++++
 tb/tb_exc_ctrl.sv | 125 ++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EXC_REDIR  = 2'd1,
    ERET_REDIR = 2'd2
  } exc_state_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline-side bundle of exc_ctrl; CP0 access signals exist only with CP0_ACCESS_EN.
interface exc_ctrl_if #(
  parameter int NUM_INT = 4
);
  logic               ovf_i;
  logic               ex_valid_i;
  logic [31:0]        pc_ex_i;
  logic               eret_i;
  logic [NUM_INT-1:0] int_req_i;
  logic               flush_o;
  logic               pc_redirect_o;
  logic [31:0]        pc_target_o;
  logic [31:0]        epc_o;
  logic [31:0]        cause_o;
  logic               exl_o;
  logic [NUM_INT-1:0] int_ack_o;
`ifdef CP0_ACCESS_EN
  logic               cp0_we_i;
  logic [4:0]         cp0_addr_i;
  logic [31:0]        cp0_wdata_i;
  logic [31:0]        cp0_rdata_o;
`endif

  modport slave (
    input  ovf_i, ex_valid_i, pc_ex_i, eret_i, int_req_i,
`ifdef CP0_ACCESS_EN
    input  cp0_we_i, cp0_addr_i, cp0_wdata_i,
    output cp0_rdata_o,
`endif
    output flush_o, pc_redirect_o, pc_target_o, epc_o, cause_o, exl_o, int_ack_o
  );

  modport master (
    output ovf_i, ex_valid_i, pc_ex_i, eret_i, int_req_i,
`ifdef CP0_ACCESS_EN
    output cp0_we_i, cp0_addr_i, cp0_wdata_i,
    input  cp0_rdata_o,
`endif
    input  flush_o, pc_redirect_o, pc_target_o, epc_o, cause_o, exl_o, int_ack_o
  );
endinterface

// File: rtl/int_pend_arb.sv
// Interrupt pending latch with mask and lowest-index-first registered acknowledge.
module int_pend_arb #(
  parameter int NUM_INT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] req,
  input  logic [NUM_INT-1:0] mask,
  input  logic               take,
  output logic [NUM_INT-1:0] pend,
  output logic [NUM_INT-1:0] ack
);

  logic [NUM_INT-1:0] low;
  logic               found;

  always_comb begin
    low   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (pend[i] && !found) begin
        low[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // A bit being acknowledged clears even if its request is still high this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ack  <= '0;
    end else begin
      pend <= (pend | (req & mask)) & ~ack;
      ack  <= take ? low : '0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: flush, PC redirect and minimal CP0 (Status/Cause/EPC).
// Optional CP0 register access port: define CP0_ACCESS_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          NUM_INT    = 4,
  parameter logic [31:0] OVF_VECTOR = 32'h0000_0080,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0100
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.slave bus
);

  exc_state_e         state;
  logic [31:0]        epc;
  logic [4:0]         code;
  logic [7:0]         ip;
  logic               exl;
  logic               ie;
  logic [NUM_INT-1:0] int_mask;
  logic [NUM_INT-1:0] pend;
  logic [NUM_INT-1:0] ack;
  logic               idle, ovf_take, eret_take, int_take, int_go;

`ifdef CP0_ACCESS_EN
  logic [7:0] im;
  assign int_mask = im[NUM_INT-1:0];
`else
  assign ie       = 1'b1;
  assign int_mask = '1;
`endif

  assign idle      = (state == IDLE);
  assign ovf_take  = idle & bus.ovf_i & bus.ex_valid_i & ~exl;
  assign eret_take = idle & bus.eret_i & exl;
  assign int_take  = idle & (|pend) & ie & ~exl & bus.ex_valid_i;
  assign int_go    = int_take & ~ovf_take & ~eret_take;

  int_pend_arb #(.NUM_INT(NUM_INT)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.int_req_i),
    .mask (int_mask),
    .take (int_go),
    .pend (pend),
    .ack  (ack)
  );

  // Software writes come first so the hardware update below wins on shared fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc   <= '0;
      code  <= EXC_INT;
      ip    <= '0;
      exl   <= 1'b0;
`ifdef CP0_ACCESS_EN
      ie    <= 1'b1;
      im    <= '1;
`endif
    end else begin
`ifdef CP0_ACCESS_EN
      if (bus.cp0_we_i) begin
        case (bus.cp0_addr_i)
          CP0_STATUS: begin
            im  <= bus.cp0_wdata_i[ST_IM_HI:ST_IM_LO];
            exl <= bus.cp0_wdata_i[ST_EXL];
            ie  <= bus.cp0_wdata_i[ST_IE];
          end
          CP0_CAUSE: code <= bus.cp0_wdata_i[6:2];
          CP0_EPC:   epc  <= bus.cp0_wdata_i;
          default: ;
        endcase
      end
`endif
      case (state)
        IDLE: begin
          if (ovf_take) begin
            epc   <= bus.pc_ex_i;
            code  <= EXC_OV;
            exl   <= 1'b1;
            state <= EXC_REDIR;
          end else if (eret_take) begin
            exl   <= 1'b0;
            state <= ERET_REDIR;
          end else if (int_take) begin
            // The EX instruction is killed and replayed from EPC on return.
            epc   <= bus.pc_ex_i;
            code  <= EXC_INT;
            ip    <= 8'(pend);
            exl   <= 1'b1;
            state <= EXC_REDIR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.pc_target_o = '0;
    case (state)
      EXC_REDIR:  bus.pc_target_o = (code == EXC_OV) ? OVF_VECTOR : INT_VECTOR;
      ERET_REDIR: bus.pc_target_o = epc;
      default:    bus.pc_target_o = '0;
    endcase
  end

  assign bus.flush_o       = ~idle | ovf_take | eret_take | int_take;
  assign bus.pc_redirect_o = ~idle;
  assign bus.epc_o         = epc;
  assign bus.cause_o       = {16'b0, ip, 1'b0, code, 2'b00};
  assign bus.exl_o         = exl;
  assign bus.int_ack_o     = ack;

`ifdef CP0_ACCESS_EN
  always_comb begin
    bus.cp0_rdata_o = '0;
    case (bus.cp0_addr_i)
      CP0_STATUS: bus.cp0_rdata_o = {16'b0, im, 6'b0, exl, ie};
      CP0_CAUSE:  bus.cp0_rdata_o = bus.cause_o;
      CP0_EPC:    bus.cp0_rdata_o = epc;
      default:    bus.cp0_rdata_o = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: per-cycle expectations queued with stimulus, checked at negedge.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exc_ctrl_if #(.NUM_INT(4)) bus ();

  exc_ctrl #(
    .NUM_INT    (4),
    .OVF_VECTOR (32'h0000_0080),
    .INT_VECTOR (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        flush;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] cause;
    logic        exl;
    logic [3:0]  ack;
  } exp_t;

  exp_t sbq[$];
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, then check them at negedge.
  task automatic cyc(input string tag, input logic rs, input logic o, input logic v,
                     input logic [31:0] pc, input logic e, input logic [3:0] rq,
                     input logic fl, input logic rd, input logic [31:0] tg,
                     input logic [31:0] ep, input logic [31:0] ca, input logic ex,
                     input logic [3:0] ak);
    exp_t x;
    rst            = rs;
    bus.ovf_i      = o;
    bus.ex_valid_i = v;
    bus.pc_ex_i    = pc;
    bus.eret_i     = e;
    bus.int_req_i  = rq;
    x.tag = tag; x.flush = fl; x.redir = rd; x.tgt = tg;
    x.epc = ep;  x.cause = ca; x.exl = ex;   x.ack = ak;
    sbq.push_back(x);
    @(negedge clk);
    x = sbq.pop_front();
    chk({x.tag, ".flush"}, 32'(bus.flush_o),       32'(x.flush));
    chk({x.tag, ".redir"}, 32'(bus.pc_redirect_o), 32'(x.redir));
    chk({x.tag, ".tgt"},   bus.pc_target_o,        x.tgt);
    chk({x.tag, ".epc"},   bus.epc_o,              x.epc);
    chk({x.tag, ".cause"}, bus.cause_o,            x.cause);
    chk({x.tag, ".exl"},   32'(bus.exl_o),         32'(x.exl));
    chk({x.tag, ".ack"},   32'(bus.int_ack_o),     32'(x.ack));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ovf_i = 1'b0; bus.ex_valid_i = 1'b0; bus.pc_ex_i = '0;
    bus.eret_i = 1'b0; bus.int_req_i = '0;
`ifdef CP0_ACCESS_EN
    bus.cp0_we_i = 1'b0; bus.cp0_addr_i = '0; bus.cp0_wdata_i = '0;
`endif
    @(posedge clk);
    #1;
    //   tag          rs o  v  pc     e  rq     fl rd tgt    epc    cause  exl ack
    cyc("rst",        1, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h0,   'h0,   0, 4'h0);
    cyc("idle",       0, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h0,   'h0,   0, 4'h0);
    // overflow entry
    cyc("ovf_T",      0, 1, 1, 'h40,  0, 4'h0,  1, 0, 'h0,   'h0,   'h0,   0, 4'h0);
    cyc("ovf_T1",     0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h80,  'h40,  'h30,  1, 4'h0);
    cyc("ovf_T2",     0, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h40,  'h30,  1, 4'h0);
    // overflow while in handler is ignored
    cyc("ovf_exl",    0, 1, 1, 'h99c, 0, 4'h0,  0, 0, 'h0,   'h40,  'h30,  1, 4'h0);
    cyc("ovf_exl2",   0, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h40,  'h30,  1, 4'h0);
    // ERET back to 0x40
    cyc("eret_T",     0, 0, 0, 'h0,   1, 4'h0,  1, 0, 'h0,   'h40,  'h30,  1, 4'h0);
    cyc("eret_T1",    0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h40,  'h40,  'h30,  0, 4'h0);
    // ERET outside handler is a NOP
    cyc("eret_nop",   0, 0, 0, 'h0,   1, 4'h0,  0, 0, 'h0,   'h40,  'h30,  0, 4'h0);
    cyc("eret_nop2",  0, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h40,  'h30,  0, 4'h0);
    // interrupt 0110 waits for a valid EX, acks lowest index
    cyc("int_req",    0, 0, 0, 'h0,   0, 4'h6,  0, 0, 'h0,   'h40,  'h30,  0, 4'h0);
    cyc("int_wait",   0, 0, 0, 'h0,   0, 4'h6,  0, 0, 'h0,   'h40,  'h30,  0, 4'h0);
    cyc("int_T",      0, 0, 1, 'h200, 0, 4'h6,  1, 0, 'h0,   'h40,  'h30,  0, 4'h0);
    cyc("int_T1",     0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h100, 'h200, 'h600, 1, 4'h2);
    cyc("int_T2",     0, 0, 0, 'h0,   0, 4'h0,  0, 0, 'h0,   'h200, 'h600, 1, 4'h0);
    // return, then still-pending bit 2 is taken at next valid EX
    cyc("eret2_T",    0, 0, 0, 'h0,   1, 4'h0,  1, 0, 'h0,   'h200, 'h600, 1, 4'h0);
    cyc("eret2_T1",   0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h200, 'h200, 'h600, 0, 4'h0);
    cyc("int2_T",     0, 0, 1, 'h204, 0, 4'h0,  1, 0, 'h0,   'h200, 'h600, 0, 4'h0);
    cyc("int2_T1",    0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h100, 'h204, 'h400, 1, 4'h4);
    cyc("eret3_T",    0, 0, 0, 'h0,   1, 4'h0,  1, 0, 'h0,   'h204, 'h400, 1, 4'h0);
    cyc("eret3_T1",   0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h204, 'h204, 'h400, 0, 4'h0);
    // overflow and pending interrupt together: overflow wins, interrupt waits
    cyc("both_req",   0, 0, 0, 'h0,   0, 4'h1,  0, 0, 'h0,   'h204, 'h400, 0, 4'h0);
    cyc("both_T",     0, 1, 1, 'h300, 0, 4'h0,  1, 0, 'h0,   'h204, 'h400, 0, 4'h0);
    cyc("both_T1",    0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h80,  'h300, 'h430, 1, 4'h0);
    cyc("both_hold",  0, 0, 1, 'h304, 0, 4'h0,  0, 0, 'h0,   'h300, 'h430, 1, 4'h0);
    cyc("eret4_T",    0, 0, 0, 'h0,   1, 4'h0,  1, 0, 'h0,   'h300, 'h430, 1, 4'h0);
    cyc("eret4_T1",   0, 0, 0, 'h0,   0, 4'h0,  1, 1, 'h300, 'h300, 'h430, 0, 4'h0);
    cyc("int3_T",     0, 0, 1, 'h308, 0, 4'h0,  1, 0, 'h0,   'h300, 'h430, 0, 4'h0);
    // reset during EXC_REDIR abandons the redirect and clears pending
    cyc("rst_mid",    1, 0, 0, 'h0,   0, 4'h2,  1, 1, 'h100, 'h308, 'h100, 1, 4'h1);
    cyc("rst_after",  0, 0, 1, 'h400, 0, 4'h0,  0, 0, 'h0,   'h0,   'h0,   0, 4'h0);
    cyc("rst_pend",   0, 0, 1, 'h404, 0, 4'h0,  0, 0, 'h0,   'h0,   'h0,   0, 4'h0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
